// File: rtl/uart_fifo_bus.sv
// Bus-attached UART with TX/RX FIFOs, programmable divisor,
// sticky error flags, interrupt and internal loopback.
module uart_fifo_bus_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [AW:0]  wp_q;
    logic [AW:0]  rp_q;
    logic [W-1:0] mem_q [2**AW];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
    end
endmodule

module uart_fifo_bus #(
    parameter int CLK_MHZ   = 25,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        RxD,
    output logic        TxD,
    output logic        irq
);
    localparam int DIV_RST_I =
        (CLK_MHZ * 1000000 + 8 * BAUD) / (16 * BAUD) - 1;
    localparam logic [15:0] DIV_RST  = 16'(DIV_RST_I);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [15:0] div_q, div_d;
    logic [15:0] pre_q, pre_d;
    logic        loop_q, loop_d;
    logic        rxie_q, rxie_d;
    logic        txie_q, txie_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic [31:0] dout_q, dout_d;
    logic        irq_q, irq_d;

    logic        rd, wr;
    logic        a_stat, a_tx, a_rx, a_ctrl;
    logic        tick;
    logic        unused_din;

    logic                 txf_push, txf_pop;
    logic                 txf_full, txf_empty;
    logic [DATA_BITS-1:0] txf_dout;
    logic                 rxf_push, rxf_pop;
    logic                 rxf_full, rxf_empty;
    logic [DATA_BITS-1:0] rxf_dout;
    logic [7:0]           rx8;

    state_t               tx_st_q, tx_st_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_busy;

    state_t               rx_st_q, rx_st_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_src, rx_fall;
    logic                 rx_set_ovr, rx_set_ferr;

    assign rd     = ce & ~we;
    assign wr     = ce & we;
    assign a_stat = (addr == 4'h0);
    assign a_tx   = (addr == 4'h4);
    assign a_rx   = (addr == 4'h8);
    assign a_ctrl = (addr == 4'hC);
    assign unused_din = ^din[31:19];

    assign tick     = (pre_q == div_q);
    assign txf_push = wr & a_tx;
    assign rxf_pop  = rd & a_rx;
    assign tx_busy  = ~txf_empty | (tx_st_q != S_IDLE);

    assign TxD  = loop_q | tx_line_q;
    assign dout = dout_q;
    assign irq  = irq_q;

    // Loopback feeds the receiver through the same synchroniser.
    assign rx_src  = loop_q ? tx_line_q : RxD;
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    uart_fifo_bus_fifo #(
        .W  (DATA_BITS),
        .AW (FIFO_AW)
    ) u_txf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (txf_push),
        .data_i  (din[DATA_BITS-1:0]),
        .pop_i   (txf_pop),
        .data_o  (txf_dout),
        .full_o  (txf_full),
        .empty_o (txf_empty)
    );

    uart_fifo_bus_fifo #(
        .W  (DATA_BITS),
        .AW (FIFO_AW)
    ) u_rxf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rxf_push),
        .data_i  (rx_sh_q),
        .pop_i   (rxf_pop),
        .data_o  (rxf_dout),
        .full_o  (rxf_full),
        .empty_o (rxf_empty)
    );

    always_comb begin
        rx8 = '0;
        rx8[DATA_BITS-1:0] = rxf_dout;
    end

    always_comb begin
        div_d  = div_q;
        loop_d = loop_q;
        rxie_d = rxie_q;
        txie_d = txie_q;
        pre_d  = (tick | (wr & a_ctrl)) ? '0 : pre_q + 16'd1;
        if (wr & a_ctrl) begin
            div_d  = din[15:0];
            loop_d = din[16];
            rxie_d = din[17];
            txie_d = din[18];
        end
        // A same-cycle set event overrides the W1C clear.
        ovr_d  = rx_set_ovr |
                 (ovr_q & ~(wr & a_stat & din[4]));
        ferr_d = rx_set_ferr |
                 (ferr_q & ~(wr & a_stat & din[5]));
        irq_d  = (rxie_q & ~rxf_empty) |
                 (txie_q & txf_empty & ~tx_busy) |
                 ovr_q | ferr_q;
        dout_d = dout_q;
        if (rd) begin
            unique case (1'b1)
                a_stat: dout_d = {25'b0, tx_busy, ferr_q, ovr_q,
                                  rxf_full, rxf_empty,
                                  txf_empty, txf_full};
                a_rx:   dout_d = rxf_empty ? '0 :
                                 {1'b1, 23'b0, rx8};
                a_ctrl: dout_d = {13'b0, txie_q, rxie_q,
                                  loop_q, div_q};
                default: dout_d = '0;
            endcase
        end
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txf_pop  = 1'b0;
        unique case (tx_st_q)
            S_IDLE: begin
                if (!txf_empty) begin
                    txf_pop  = 1'b1;
                    tx_sh_d  = txf_dout;
                    tx_cnt_d = '0;
                    tx_st_d  = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'hF) begin
                        tx_bit_d = '0;
                        tx_st_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'hF) begin
                        if (tx_bit_q == LAST_BIT) begin
                            tx_st_d = S_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                            tx_sh_d  = tx_sh_q >> 1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'hF) begin
                        if (!txf_empty) begin
                            txf_pop = 1'b1;
                            tx_sh_d = txf_dout;
                            tx_st_d = S_START;
                        end else begin
                            tx_st_d = S_IDLE;
                        end
                    end
                end
            end
            default: tx_st_d = S_IDLE;
        endcase
        // Line is registered alongside the state it belongs to.
        unique case (tx_st_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_sh_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_st_d     = rx_st_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rxf_push    = 1'b0;
        rx_set_ovr  = 1'b0;
        rx_set_ferr = 1'b0;
        unique case (rx_st_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d = '0;
                    rx_st_d  = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d = '0;
                        rx_bit_d = '0;
                        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'hF) begin
                        rx_sh_d  = {rx_s2_q,
                                    rx_sh_q[DATA_BITS-1:1]};
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT)
                            rx_st_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'hF) begin
                        rx_st_d = S_IDLE;
                        if (!rx_s2_q)      rx_set_ferr = 1'b1;
                        else if (rxf_full) rx_set_ovr  = 1'b1;
                        else               rxf_push    = 1'b1;
                    end
                end
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= DIV_RST;
            pre_q     <= '0;
            loop_q    <= 1'b0;
            rxie_q    <= 1'b0;
            txie_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            dout_q    <= '0;
            irq_q     <= 1'b0;
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_line_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            pre_q     <= pre_d;
            loop_q    <= loop_d;
            rxie_q    <= rxie_d;
            txie_q    <= txie_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_line_q <= tx_line_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_s1_q   <= rx_src;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end
endmodule

// File: tb/tb_uart_fifo_bus.sv
// Scoreboard bench for uart_fifo_bus: reads and pin probes are
// queued with expectations and checked by a separate monitor.
module tb_uart_fifo_bus;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        RxD = 1'b1;
    logic        TxD;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string nm;
        int    kind;
        logic  exp;
    } pin_t;

    rd_t  rdq[$];
    pin_t pinq[$];
    rd_t  re;
    pin_t pe;
    logic rd_seen = 1'b0;
    logic pv;

    always #5 clk = ~clk;

    uart_fifo_bus dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .RxD   (RxD),
        .TxD   (TxD),
        .irq   (irq)
    );

    function automatic void cmp(string nm, logic [31:0] got,
                                logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endfunction

    always @(posedge clk) rd_seen <= ce & ~we;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read got=%h", dout);
            end else begin
                re = rdq.pop_front();
                cmp(re.nm, dout, re.exp);
            end
        end
        while (pinq.size() > 0) begin
            pe = pinq.pop_front();
            pv = (pe.kind == 0) ? TxD : irq;
            cmp(pe.nm, {31'b0, pv}, {31'b0, pe.exp});
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [3:0] a, logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; din = d;
        step();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(logic [3:0] a, logic [31:0] e, string nm);
        ce = 1'b1; we = 1'b0; addr = a;
        rdq.push_back('{nm: nm, exp: e});
        step();
        ce = 1'b0;
    endtask

    task automatic pin(int k, logic e, string nm);
        pinq.push_back('{nm: nm, kind: k, exp: e});
    endtask

    task automatic send_rx(logic [7:0] b, logic stopv);
        RxD = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            step(16);
        end
        RxD = stopv;
        step(16);
        RxD = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic       bits [20];
        int         lat;

        step(3);
        rst_n = 1'b1;
        step(2);

        // 1: reset state
        pin(0, 1'b1, "rst_txd");
        pin(1, 1'b0, "rst_irq");
        rd(4'h0, 32'h0000_0006, "rst_status");
        rd(4'hC, 32'h0000_000D, "rst_ctrl");
        rd(4'h4, 32'h0, "txdata_read_zero");
        rd(4'h2, 32'h0, "undecoded_read");
        wr(4'h1, 32'hFFFF_FFFF);
        rd(4'hC, 32'h0000_000D, "undecoded_write_ignored");

        // 2: single loopback byte
        wr(4'hC, 32'h0001_0000);
        wr(4'h4, 32'h0000_00A5);
        for (int i = 0; i < 170; i++) begin
            if (i % 32 == 0) pin(0, 1'b1, "lb_txd_high");
            step();
        end
        rd(4'h0, 32'h0000_0002, "lb_status");
        rd(4'h8, 32'h8000_00A5, "lb_rxdata");
        rd(4'h8, 32'h0, "lb_rx_empty_read");
        rd(4'h0, 32'h0000_0006, "lb_status_after");

        // 3: TX waveform, back-to-back frames
        wr(4'hC, 32'h0);
        b0 = 8'h55;
        b1 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            bits[1 + i]  = b0[i];
            bits[11 + i] = b1[i];
        end
        bits[0] = 1'b0; bits[9] = 1'b1;
        bits[10] = 1'b0; bits[19] = 1'b1;
        wr(4'h4, {24'b0, b0});
        pin(0, 1'b1, "tx_not_yet_low");
        wr(4'h4, {24'b0, b1});
        lat = 1;
        while (TxD && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat < 1 || lat > 2) begin
            errors++;
            $display("FAIL tx_start_latency got=%0d exp=1..2", lat);
        end
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (j == 0 || j == 15)
                    pin(0, bits[k], $sformatf("tx_bit%0d_c%0d", k, j));
                step();
            end
        end
        pin(0, 1'b1, "tx_idle_after");
        rd(4'h0, 32'h0000_0006, "tx_status_idle");

        // 4: overrun with 17 looped bytes
        wr(4'hC, 32'h0001_0000);
        for (int i = 0; i <= 16; i++) wr(4'h4, i);
        step(2800);
        rd(4'h0, 32'h0000_001A, "ovr_status");
        pin(1, 1'b1, "irq_overrun");
        for (int i = 0; i < 16; i++)
            rd(4'h8, 32'h8000_0000 | i, $sformatf("ovr_rx%0d", i));
        rd(4'h8, 32'h0, "ovr_rx_drained");
        rd(4'h0, 32'h0000_0016, "ovr_status_drained");
        wr(4'h0, 32'h0000_0010);
        rd(4'h0, 32'h0000_0006, "ovr_cleared");
        step();
        pin(1, 1'b0, "irq_ovr_cleared");

        // 5: external frame error and glitch
        wr(4'hC, 32'h0);
        step(4);
        send_rx(8'h3C, 1'b0);
        step(20);
        rd(4'h0, 32'h0000_0026, "ferr_status");
        pin(1, 1'b1, "irq_ferr");
        wr(4'h0, 32'h0000_0020);
        rd(4'h0, 32'h0000_0006, "ferr_cleared");
        RxD = 1'b0;
        step(4);
        RxD = 1'b1;
        step(40);
        rd(4'h0, 32'h0000_0006, "glitch_status");
        pin(1, 1'b0, "irq_glitch");

        // 6: rx irq enable, pop, reset mid-frame
        wr(4'hC, 32'h0002_0000);
        step(2);
        pin(1, 1'b0, "irq_rxie_empty");
        wr(4'hC, 32'h0003_0000);
        wr(4'h4, 32'h0000_005A);
        step(170);
        pin(1, 1'b1, "irq_rx_data");
        rd(4'h8, 32'h8000_005A, "irq_rx_byte");
        step();
        pin(1, 1'b0, "irq_after_pop");
        wr(4'hC, 32'h0);
        wr(4'h4, 32'h0000_0000);
        wr(4'h4, 32'h0000_0000);
        step(20);
        pin(0, 1'b0, "tx_midframe_low");
        step();
        rst_n = 1'b0;
        #1;
        pin(0, 1'b1, "txd_on_reset");
        step(3);
        rst_n = 1'b1;
        step(2);
        pin(0, 1'b1, "txd_after_reset");
        rd(4'h0, 32'h0000_0006, "status_after_reset");
        rd(4'hC, 32'h0000_000D, "ctrl_after_reset");
        step(5);

        checks++;
        if (rdq.size() != 0 || pinq.size() != 0) begin
            errors++;
            $display("FAIL pending_checks got=%0d exp=0",
                     rdq.size() + pinq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
